// File: rtl/count_sequencer.sv
// ============================================================================
// count_sequencer : run/pause/done sequencer for the 8-bit step counter.
// Optional one-shot mode compiled in with SEQ_ONESHOT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module count_sequencer #(
    parameter int DIV   = 50000000,
    parameter int DIV_W = 26
) (
    input  logic       Clk,
    input  logic       Clear,
    input  logic       start,
    input  logic       stop,
    input  logic       mode,
    input  logic [7:0] target,
    input  logic [7:0] q,
    output logic       cnt_en,
    output logic       cnt_clr_n,
    output logic       running,
    output logic       done,
    output logic       wrap
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_RUN  = 3'd2,
        S_HOLD = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(DIV - 1);

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic             r_start_q;
    logic             r_stop_q;

    logic w_start_rise;
    logic w_stop_rise;
    logic w_tick;
    logic w_match;

    assign w_start_rise = start & ~r_start_q;
    assign w_stop_rise  = stop  & ~r_stop_q;
    assign w_tick       = (r_state == S_RUN) && (r_div == c_div_last);

`ifdef SEQ_ONESHOT_EN
    assign w_match = mode && (q == target);
    assign wrap    = cnt_en & (q == 8'hFF) & ~mode;
    assign done    = (r_state == S_DONE);
`else
    logic w_unused;
    assign w_unused = ^{mode, target};
    assign w_match  = 1'b0;
    assign wrap     = cnt_en & (q == 8'hFF);
    assign done     = 1'b0;
`endif

    // Gating with Clear keeps the counter quiet on the reset edge itself.
    assign cnt_en    = Clear & w_tick & ~w_match;
    assign cnt_clr_n = Clear & (r_state != S_CLR);
    assign running   = (r_state == S_RUN);

    always_ff @(posedge Clk) begin
        if (!Clear) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_start_q <= 1'b1;
            r_stop_q  <= 1'b1;
        end else begin
            r_start_q <= start;
            r_stop_q  <= stop;
            unique case (r_state)
                S_IDLE: begin
                    if (w_start_rise && !w_stop_rise)
                        r_state <= S_CLR;
                end
                S_CLR: begin
                    r_div   <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_match)
                        r_state <= S_DONE;
                    else if (w_stop_rise)
                        r_state <= S_HOLD;      // divider keeps its partial period
                    else if (w_tick)
                        r_div <= '0;
                    else
                        r_div <= r_div + DIV_W'(1);
                end
                S_HOLD: begin
                    if (w_stop_rise)
                        r_state <= S_IDLE;
                    else if (w_start_rise)
                        r_state <= S_RUN;
                end
                S_DONE: begin
                    if (w_stop_rise)
                        r_state <= S_IDLE;
                    else if (w_start_rise)
                        r_state <= S_CLR;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_count_sequencer.sv
// ============================================================================
// tb_count_sequencer : randomized bench for count_sequencer with a cycle-level
// reference model and a behavioural 8-bit counter.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_count_sequencer;

    localparam int DIV   = 4;
    localparam int DIV_W = 3;

`ifdef SEQ_ONESHOT_EN
    localparam bit ONESHOT = 1'b1;
`else
    localparam bit ONESHOT = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_CLR  = 1;
    localparam int M_RUN  = 2;
    localparam int M_HOLD = 3;
    localparam int M_DONE = 4;

    logic       clk = 1'b0;
    logic       clear, start, stop, mode;
    logic [7:0] target;
    logic [7:0] q = 8'd0;
    logic       cnt_en, cnt_clr_n, running, done, wrap;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: phase = cycles elapsed in the current step period.
    int m_st, m_phase, m_q;
    bit m_start_prev, m_stop_prev;

    always #5 clk = ~clk;

    count_sequencer #(.DIV(DIV), .DIV_W(DIV_W)) dut (
        .Clk       (clk),
        .Clear     (clear),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .target    (target),
        .q         (q),
        .cnt_en    (cnt_en),
        .cnt_clr_n (cnt_clr_n),
        .running   (running),
        .done      (done),
        .wrap      (wrap)
    );

    // The counter datapath being sequenced.
    always @(posedge clk) begin
        if (!cnt_clr_n)
            q <= 8'd0;
        else if (cnt_en)
            q <= q + 8'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        m_st         = M_IDLE;
        m_phase      = 0;
        m_q          = 0;
        m_start_prev = 1'b1;
        m_stop_prev  = 1'b1;
    endtask

    task automatic step();
        bit e_match, e_tick, e_en, e_wrap, rs, rt;
        @(negedge clk);
        e_match = ONESHOT && mode && (m_q == int'(target));
        e_tick  = (m_st == M_RUN) && (m_phase == DIV - 1);
        e_en    = clear && e_tick && !e_match;
        e_wrap  = e_en && (m_q == 255) && !(ONESHOT && mode);
        check("cnt_en",    32'(cnt_en),    32'(e_en));
        check("cnt_clr_n", 32'(cnt_clr_n), 32'(clear && (m_st != M_CLR)));
        check("running",   32'(running),   32'(m_st == M_RUN));
        check("done",      32'(done),      32'(m_st == M_DONE));
        check("wrap",      32'(wrap),      32'(e_wrap));
        check("q",         32'(q),         32'(m_q));
        @(posedge clk);
        if (!clear) begin
            model_reset();
        end else begin
            rs = start && !m_start_prev;
            rt = stop  && !m_stop_prev;
            if (m_st == M_CLR)
                m_q = 0;
            else if (e_en)
                m_q = (m_q + 1) % 256;
            case (m_st)
                M_IDLE: if (rs && !rt) m_st = M_CLR;
                M_CLR: begin
                    m_st    = M_RUN;
                    m_phase = 0;
                end
                M_RUN: begin
                    if (e_match)      m_st = M_DONE;
                    else if (rt)      m_st = M_HOLD;
                    else              m_phase = (m_phase + 1) % DIV;
                end
                M_HOLD: begin
                    if (rt)      m_st = M_IDLE;
                    else if (rs) m_st = M_RUN;
                end
                M_DONE: begin
                    if (rt)      m_st = M_IDLE;
                    else if (rs) m_st = M_CLR;
                end
                default: m_st = M_IDLE;
            endcase
            m_start_prev = start;
            m_stop_prev  = stop;
        end
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press_start();
        start = 1'b1; step();
        start = 1'b0; step();
    endtask

    task automatic press_stop();
        stop = 1'b1; step();
        stop = 1'b0; step();
    endtask

    task automatic do_reset();
        clear = 1'b0; steps(3);
        clear = 1'b1;
    endtask

    initial begin
        clear = 1'b0; start = 1'b1; stop = 1'b0; mode = 1'b0; target = 8'd0;
        @(posedge clk); #1;
        model_reset();

        // Start held through reset must not launch a run.
        steps(3);
        clear = 1'b1; steps(6);
        start = 1'b0; steps(2);

        // Free-run across a full wrap.
        mode = 1'b0;
        press_start();
        steps(256 * DIV + 12);

        // One-shot to 5, then restart.
        do_reset();
        mode = 1'b1; target = 8'd5;
        press_start(); steps(30);
        press_start(); steps(30);

        // Pause two cycles after a tick, resume ten cycles later.
        do_reset();
        mode = 1'b0;
        press_start();
        for (int i = 0; i < 20 && !(m_st == M_RUN && m_phase == DIV - 1); i++) step();
        steps(2);
        stop = 1'b1; step(); stop = 1'b0;
        steps(10);
        press_start(); steps(8);

        // Simultaneous edges in HOLD, then in IDLE.
        press_stop(); steps(2);
        start = 1'b1; stop = 1'b1; step();
        start = 1'b0; stop = 1'b0; steps(3);
        start = 1'b1; stop = 1'b1; step();
        start = 1'b0; stop = 1'b0; steps(4);

        // Target zero.
        mode = 1'b1; target = 8'd0;
        press_start(); steps(10);

        // Reset in the middle of a run.
        mode = 1'b0;
        press_start(); steps(9);
        clear = 1'b0; step();
        clear = 1'b1; steps(4);

        // One-shot request with low target; free-runs past it when compiled out.
        mode = 1'b1; target = 8'd3;
        press_start(); steps(30);

        // Randomized traffic.
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: press_start();
                3:       press_stop();
                4: begin
                    start = 1'b1; stop = 1'b1; step();
                    start = 1'b0; stop = 1'b0; step();
                end
                5: begin
                    mode   = 1'($urandom_range(0, 1));
                    target = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 12));
                    step();
                end
                6: begin
                    clear = 1'b0; steps($urandom_range(1, 2));
                    clear = 1'b1; step();
                end
                default: steps($urandom_range(1, 12));
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
